// File: rtl/wb_switch_pkg.sv
// Shared state encoding, bus bundles and default decode constants for the
// dual-master Wishbone switch.
package wb_switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    DERR = 2'd3
  } sw_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } wb_rsp_t;

  localparam int unsigned SRAM_DEC_W_DEF     = 8;
  localparam logic [7:0]  SRAM_ADDR_DEF      = 8'h00;
  localparam int unsigned PERIP_DEC_W_DEF    = 4;
  localparam logic [3:0]  PERIP_ADDR_DEF     = 4'h9;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/wb_switch_watchdog.sv
// Counts consecutive unanswered strobe cycles; expired_o flags the cycle whose
// increment would reach TIMEOUT_CYCLES, so the error cycle lands on the next one.
module wb_switch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = run_i && !clear_i && (cnt_q == LIMIT_M1);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || !run_i || expired_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_dual_master_switch.sv
// Two-master / two-target Wishbone switch: round-robin grant held for a whole
// cyc, MSB address decode, and a one-cycle error for unmapped or timed-out strobes.
module wb_dual_master_switch
  import wb_switch_pkg::*;
#(
  parameter int unsigned            SRAM_DEC_W     = SRAM_DEC_W_DEF,
  parameter logic [SRAM_DEC_W-1:0]  SRAM_ADDR      = SRAM_ADDR_DEF,
  parameter int unsigned            PERIP_DEC_W    = PERIP_DEC_W_DEF,
  parameter logic [PERIP_DEC_W-1:0] PERIP_ADDR     = PERIP_ADDR_DEF,
  parameter int unsigned            TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic        t0_wb_cyc_o,
  output logic        t0_wb_stb_o,
  output logic        t0_wb_we_o,
  output logic [31:0] t0_wb_adr_o,
  output logic [3:0]  t0_wb_sel_o,
  output logic [31:0] t0_wb_dat_o,
  input  logic [31:0] t0_wb_dat_i,
  input  logic        t0_wb_ack_i,
  input  logic        t0_wb_err_i,
  output logic        t1_wb_cyc_o,
  output logic        t1_wb_stb_o,
  output logic        t1_wb_we_o,
  output logic [31:0] t1_wb_adr_o,
  output logic [3:0]  t1_wb_sel_o,
  output logic [31:0] t1_wb_dat_o,
  input  logic [31:0] t1_wb_dat_i,
  input  logic        t1_wb_ack_i,
  input  logic        t1_wb_err_i
);

  sw_state_e state_q, state_d;
  logic      owner_q, owner_d;   // current owner in OWN/DERR, last grant in IDLE
  logic      rr_pick;
  logic      gnt_vld;
  wb_req_t   m0_req, m1_req, g_req;
  wb_rsp_t   t0_rsp, t1_rsp, r_rsp;
  logic      sram_hit, perip_hit, unmapped, stb_block;
  logic      wd_run, wd_expired;

  assign m0_req = '{cyc: m0_wb_cyc_i, stb: m0_wb_stb_i, we: m0_wb_we_i,
                    adr: m0_wb_adr_i, sel: m0_wb_sel_i, dat: m0_wb_dat_i};
  assign m1_req = '{cyc: m1_wb_cyc_i, stb: m1_wb_stb_i, we: m1_wb_we_i,
                    adr: m1_wb_adr_i, sel: m1_wb_sel_i, dat: m1_wb_dat_i};
  assign t0_rsp = '{ack: t0_wb_ack_i, err: t0_wb_err_i, dat: t0_wb_dat_i};
  assign t1_rsp = '{ack: t1_wb_ack_i, err: t1_wb_err_i, dat: t1_wb_dat_i};

  // Grant is withheld while reset is high so a reset mid-transfer passes no response.
  assign gnt_vld = !wb_rst_i && (state_q != IDLE);
  assign g_req   = gnt_vld ? (owner_q ? m1_req : m0_req) : '0;

  assign sram_hit  = (g_req.adr[31 -: SRAM_DEC_W] == SRAM_ADDR);
  assign perip_hit = !sram_hit && (g_req.adr[31 -: PERIP_DEC_W] == PERIP_ADDR);
  assign unmapped  = !sram_hit && !perip_hit;
  assign stb_block = (state_q == DERR);

  assign t0_wb_cyc_o = g_req.cyc && sram_hit;
  assign t0_wb_stb_o = g_req.stb && sram_hit && !stb_block;
  assign t0_wb_we_o  = g_req.we;
  assign t0_wb_adr_o = g_req.adr;
  assign t0_wb_sel_o = g_req.sel;
  assign t0_wb_dat_o = g_req.dat;
  assign t1_wb_cyc_o = g_req.cyc && perip_hit;
  assign t1_wb_stb_o = g_req.stb && perip_hit && !stb_block;
  assign t1_wb_we_o  = g_req.we;
  assign t1_wb_adr_o = g_req.adr;
  assign t1_wb_sel_o = g_req.sel;
  assign t1_wb_dat_o = g_req.dat;

  always_comb begin
    r_rsp = '0;
    if (state_q == DERR) begin
      r_rsp.err = 1'b1;
    end else if (sram_hit) begin
      r_rsp = t0_rsp;
    end else if (perip_hit) begin
      r_rsp = t1_rsp;
    end
  end

  assign m0_wb_dat_o = (gnt_vld && !owner_q) ? r_rsp.dat : '0;
  assign m0_wb_ack_o = gnt_vld && !owner_q && r_rsp.ack;
  assign m0_wb_err_o = gnt_vld && !owner_q && r_rsp.err;
  assign m1_wb_dat_o = (gnt_vld && owner_q) ? r_rsp.dat : '0;
  assign m1_wb_ack_o = gnt_vld && owner_q && r_rsp.ack;
  assign m1_wb_err_o = gnt_vld && owner_q && r_rsp.err;

  assign wd_run = gnt_vld && !stb_block && g_req.stb && !r_rsp.ack && !r_rsp.err;

  wb_switch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .run_i     (wd_run),
    .clear_i   (stb_block),
    .expired_o (wd_expired)
  );

  assign rr_pick = (m0_wb_cyc_i && m1_wb_cyc_i) ? !owner_q : m1_wb_cyc_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i || m1_wb_cyc_i) begin
          owner_d = rr_pick;
          state_d = rr_pick ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (!g_req.cyc) begin
          state_d = IDLE;
        end else if ((g_req.stb && unmapped) || wd_expired) begin
          state_d = DERR;
        end
      end
      DERR: begin
        state_d = !g_req.cyc ? IDLE : (owner_q ? OWN1 : OWN0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_wb_dual_master_switch.sv
// Directed bench for the dual-master switch: decode, arbitration, reset,
// unmapped error and watchdog timeout.
module tb_wb_dual_master_switch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        t0_cyc, t0_stb, t0_we, t0_ack, t0_err;
  logic [31:0] t0_adr, t0_wdat, t0_rdat;
  logic [3:0]  t0_sel;
  logic        t1_cyc, t1_stb, t1_we, t1_ack, t1_err;
  logic [31:0] t1_adr, t1_wdat, t1_rdat;
  logic [3:0]  t1_sel;

  int checks = 0;
  int errors = 0;

  wb_dual_master_switch dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_sel_i(m0_sel), .m0_wb_dat_i(m0_wdat),
    .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_sel_i(m1_sel), .m1_wb_dat_i(m1_wdat),
    .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
    .t0_wb_cyc_o(t0_cyc), .t0_wb_stb_o(t0_stb), .t0_wb_we_o(t0_we),
    .t0_wb_adr_o(t0_adr), .t0_wb_sel_o(t0_sel), .t0_wb_dat_o(t0_wdat),
    .t0_wb_dat_i(t0_rdat), .t0_wb_ack_i(t0_ack), .t0_wb_err_i(t0_err),
    .t1_wb_cyc_o(t1_cyc), .t1_wb_stb_o(t1_stb), .t1_wb_we_o(t1_we),
    .t1_wb_adr_o(t1_adr), .t1_wb_sel_o(t1_sel), .t1_wb_dat_o(t1_wdat),
    .t1_wb_dat_i(t1_rdat), .t1_wb_ack_i(t1_ack), .t1_wb_err_i(t1_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_wdat = '0;
    t0_ack = 0; t0_err = 0; t0_rdat = '0;
    t1_ack = 0; t1_err = 0; t1_rdat = '0;
    tick();
    tick();
    chk("rst_t0_stb", t0_stb, 0);
    chk("rst_t1_stb", t1_stb, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m0_err", m0_err, 0);
    chk("rst_m1_err", m1_err, 0);
    rst = 1'b0;

    // SRAM read by m0, ack on the third strobe cycle
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010; m0_sel = 4'hF;
    #1;
    chk("rd_idle_t0_stb", t0_stb, 0);
    tick();
    chk("rd_t0_stb", t0_stb, 1);
    chk("rd_t0_adr", t0_adr, 32'h0000_0010);
    chk("rd_t1_stb", t1_stb, 0);
    chk("rd_m0_ack_early", m0_ack, 0);
    tick();
    chk("rd_m0_ack_wait", m0_ack, 0);
    tick();
    t0_ack = 1; t0_rdat = 32'hDEAD_BEEF;
    #1;
    chk("rd_m0_dat", m0_rdat, 32'hDEAD_BEEF);
    chk("rd_m0_ack", m0_ack, 1);
    chk("rd_m1_ack", m1_ack, 0);
    chk("rd_m1_dat", m1_rdat, 32'h0);
    chk("rd_t1_stb_ack", t1_stb, 0);
    tick();
    t0_err = 1;
    #1;
    chk("ackerr_m0_ack", m0_ack, 1);
    chk("ackerr_m0_err", m0_err, 1);
    tick();
    t0_ack = 0; t0_err = 0; t0_rdat = '0;
    m0_cyc = 0; m0_stb = 0;
    #1;
    chk("rd_drop_t0_cyc", t0_cyc, 0);
    tick();

    // reset in the middle of an OWN0 transfer
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0020;
    tick();
    chk("rst_mid_t0_stb", t0_stb, 1);
    rst = 1; t0_ack = 1; m0_cyc = 0; m0_stb = 0;
    tick();
    rst = 0;
    #1;
    chk("post_rst_m0_ack", m0_ack, 0);
    chk("post_rst_m0_err", m0_err, 0);
    chk("post_rst_t0_stb", t0_stb, 0);
    chk("post_rst_t1_stb", t1_stb, 0);
    t0_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h9000_0004; m1_sel = 4'b0011;
    m1_wdat = 32'hCAFE_F00D;
    tick();
    chk("arb1_t0_stb", t0_stb, 1);
    chk("arb1_t1_stb", t1_stb, 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("arb_idle_t1_stb", t1_stb, 0);
    tick();
    chk("wr_t1_stb", t1_stb, 1);
    chk("wr_t1_cyc", t1_cyc, 1);
    chk("wr_t1_adr", t1_adr, 32'h9000_0004);
    chk("wr_t1_sel", t1_sel, 4'b0011);
    chk("wr_t1_we", t1_we, 1);
    chk("wr_t1_dat", t1_wdat, 32'hCAFE_F00D);
    chk("wr_t0_cyc", t0_cyc, 0);
    chk("wr_t0_stb", t0_stb, 0);
    t1_ack = 1;
    #1;
    chk("wr_m1_ack", m1_ack, 1);
    chk("wr_m0_ack", m0_ack, 0);
    tick();
    t1_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1;
    m1_cyc = 1; m1_stb = 1;
    tick();
    chk("arb2_t0_stb", t0_stb, 1);
    chk("arb2_t1_stb", t1_stb, 0);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();
    tick();

    // unmapped access
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000_0000;
    tick();
    chk("unm_t0_stb", t0_stb, 0);
    chk("unm_t1_stb", t1_stb, 0);
    chk("unm_err_early", m0_err, 0);
    tick();
    chk("unm_m0_err", m0_err, 1);
    chk("unm_m0_ack", m0_ack, 0);
    chk("unm_derr_t0_stb", t0_stb, 0);
    chk("unm_derr_t1_stb", t1_stb, 0);
    m0_stb = 0;
    tick();
    chk("unm_err_once", m0_err, 0);
    m0_stb = 1;
    tick();
    m0_cyc = 0; m0_stb = 0;
    #1;
    chk("derr_drop_err", m0_err, 1);
    tick();
    chk("derr_drop_idle_err", m0_err, 0);
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h9000_0004;
    tick();
    chk("derr_drop_m1_gnt", t1_stb, 1);
    m1_cyc = 0; m1_stb = 0;
    tick();
    tick();

    // watchdog: SRAM never answers
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
    tick();
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      if (m0_err !== 1'b0 || t0_stb !== 1'b1) bad++;
      tick();
    end
    chk("wd_quiet", bad, 0);
    chk("wd_m0_err", m0_err, 1);
    chk("wd_t0_stb", t0_stb, 0);
    chk("wd_t0_cyc", t0_cyc, 1);
    chk("wd_m0_ack", m0_ack, 0);
    m0_stb = 0;
    tick();
    chk("wd_err_once", m0_err, 0);
    m0_cyc = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dual_master_switch.md
WB_DUAL_MASTER_SWITCH -- requirements
Module: wb_dual_master_switch

Interface
REQ-001 SHALL have parameter SRAM_DEC_W, default 8, number of address MSBs decoded for the SRAM target.
REQ-002 SHALL have parameter SRAM_ADDR, default 8'h00, SRAM match value on adr[31:32-SRAM_DEC_W].
REQ-003 SHALL have parameter PERIP_DEC_W, default 4, number of address MSBs decoded for the peripheral target.
REQ-004 SHALL have parameter PERIP_ADDR, default 4'h9, peripheral match value on adr[31:32-PERIP_DEC_W].
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of stb cycles without ack/err.
REQ-006 SHALL have ports: wb_clk_i input 1, sole clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: wb_rst_i input 1, synchronous active-high reset.
REQ-008 SHALL have, for masters m0 (CPU, n=0) and m1 (debug, n=1): mn_wb_cyc_i, mn_wb_stb_i, mn_wb_we_i input 1; mn_wb_adr_i input 32; mn_wb_sel_i input 4; mn_wb_dat_i input 32.
REQ-009 SHALL have, per master: mn_wb_dat_o output 32; mn_wb_ack_o, mn_wb_err_o output 1.
REQ-010 SHALL have, for targets t0 (SRAM) and t1 (peripheral): tn_wb_cyc_o, tn_wb_stb_o, tn_wb_we_o output 1; tn_wb_adr_o output 32; tn_wb_sel_o output 4; tn_wb_dat_o output 32.
REQ-011 SHALL have, per target: tn_wb_dat_i input 32; tn_wb_ack_i, tn_wb_err_i input 1.

Function
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1, DERR.
REQ-013 In IDLE, with one cyc high, SHALL go to OWN of that master the next cycle; with both high, SHALL grant the master not granted last (round-robin).
REQ-014 In OWNn, SHALL hold the grant while mn_wb_cyc_i=1, SHALL return to IDLE the cycle after cyc drops, and SHALL NOT re-arbitrate mid-cycle.
REQ-015 Decode from the granted adr: SRAM match takes precedence over peripheral match; no match means unmapped.
REQ-016 tn_wb_cyc_o/stb_o SHALL equal the granted master's cyc/stb ANDed with the target select; adr/sel/we/dat SHALL be routed from the granted master (zero when none is granted).
REQ-017 The granted master's dat_o/ack_o/err_o SHALL be the selected target's dat_i/ack_i/err_i combinationally (zero-latency path); the non-granted master SHALL see ack=err=0 and dat=0.
REQ-018 For unmapped stb, SHALL assert no target stb, SHALL enter DERR, and SHALL assert err to the owner for exactly one cycle, then return to OWNn.
REQ-019 An 8-bit (or clog2(TIMEOUT_CYCLES+1)) watchdog SHALL count while the owner's stb=1 and ack/err=0, and SHALL clear on ack, err, or stb=0.
REQ-020 When the watchdog reaches TIMEOUT_CYCLES, SHALL enter DERR (one-cycle err to the owner) with target stb forced 0 that cycle, and SHALL clear the watchdog.
REQ-021 A target ack and err that are simultaneous SHALL both be passed through; the master resolves them.
REQ-022 On a cyc drop during DERR, SHALL still complete the err cycle, then go to IDLE.

Reset
REQ-023 Reset SHALL force state IDLE, last-grant=m1 (so m0 wins first contention), watchdog=0, and all target cyc/stb and master ack/err=0 in the cycle following the reset edge.
REQ-024 Reset mid-transfer SHALL abandon the transfer without generating ack or err.

Structure
REQ-025 FSM state encoding and the default decode constants SHALL live in shared package wb_switch_pkg.
REQ-026 The watchdog SHALL be sub-module wb_switch_watchdog (inputs: clk, rst, run, clear; output: expired).

Verification
REQ-027 m0 read at 0x0000_0010, SRAM acks after 2 cycles with 0xDEADBEEF -> m0 dat=0xDEADBEEF with ack; t1 stb stays 0.
REQ-028 m0 and m1 both raise cyc in the same cycle after reset -> m0 granted first; after m0 cyc drops, m1 granted; on the next simultaneous request, m0 is granted.
REQ-029 m1 write to 0x9000_0004, sel=4'b0011 -> t1 sees adr 0x9000_0004, sel 4'b0011, we=1; t0 idle.
REQ-030 m0 access to 0x4000_0000 (unmapped) -> m0 err for exactly 1 cycle, no target stb.
REQ-031 SRAM never acks, TIMEOUT_CYCLES=255 -> m0 err on the 256th stb cycle, t0 stb low that cycle.
REQ-032 wb_rst_i asserted during an OWN0 transfer -> next cycle IDLE, all stb/ack/err=0; first post-reset contention granted to m0.
